// File: rtl/fft_out_pingpong_ctrl.sv
// Ping-pong controller between the cbfp2 writer and the bit-reversed FFT output reader.
// The writer fills one bank a block at a time while the reader drains the other bank
// in bit-reversed sample order.
module fft_out_pingpong_ctrl #(
  parameter int unsigned BLK_PER_FRAME  = 16,
  parameter int unsigned SAMP_PER_FRAME = 512
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cbfp2_pop,
  output logic       wr_bank,
  output logic [3:0] wr_blk,
  output logic [1:0] bank_full,
  output logic [9:0] rd_addr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done,
  output logic       ovf_err
);

  localparam int unsigned CntW = $clog2(SAMP_PER_FRAME);
  localparam logic [3:0] LastBlk = 4'(BLK_PER_FRAME - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(SAMP_PER_FRAME - 1);

  typedef enum logic {StIdle, StRead} state_e;

  state_e          state_q, state_d;
  logic            wr_bank_q, wr_bank_d;
  logic [3:0]      wr_blk_q, wr_blk_d;
  logic [1:0]      bank_full_q, bank_full_d;
  logic            ovf_err_q, ovf_err_d;
  logic            rd_bank_q, rd_bank_d;
  logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
  logic            frame_done_q, frame_done_d;
  logic [CntW-1:0] rd_cnt_rev;
  logic            wr_set;
  logic            rd_clr;

  // Write side: count blocks into the current bank, flag pops that hit a full bank.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_blk_d  = wr_blk_q;
    ovf_err_d = ovf_err_q;
    wr_set    = 1'b0;
    if (cbfp2_pop) begin
      if (bank_full_q[wr_bank_q]) begin
        ovf_err_d = 1'b1;
      end else if (wr_blk_q == LastBlk) begin
        wr_set    = 1'b1;
        wr_blk_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_blk_d = wr_blk_q + 4'd1;
      end
    end
  end

  // Read FSM: wait for the read bank to fill, then stream one address per handshake.
  always_comb begin
    state_d      = state_q;
    rd_cnt_d     = rd_cnt_q;
    rd_bank_d    = rd_bank_q;
    frame_done_d = 1'b0;
    rd_clr       = 1'b0;
    out_valid    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bank_full_q[rd_bank_q]) begin
          state_d  = StRead;
          rd_cnt_d = '0;
        end
      end
      StRead: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (rd_cnt_q == LastCnt) begin
            rd_clr       = 1'b1;
            rd_bank_d    = ~rd_bank_q;
            rd_cnt_d     = '0;
            frame_done_d = 1'b1;
            state_d      = StIdle;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bank flags: set and clear always hit different banks, so both may apply in one edge.
  always_comb begin
    bank_full_d = bank_full_q;
    if (wr_set) bank_full_d[wr_bank_q] = 1'b1;
    if (rd_clr) bank_full_d[rd_bank_q] = 1'b0;
  end

  // Bit-reverse the sample counter to form the low address bits.
  always_comb begin
    rd_cnt_rev = '0;
    for (int i = 0; i < int'(CntW); i++) begin
      rd_cnt_rev[i] = rd_cnt_q[CntW-1-i];
    end
  end

  assign rd_addr    = {rd_bank_q, rd_cnt_rev};
  assign wr_bank    = wr_bank_q;
  assign wr_blk     = wr_blk_q;
  assign bank_full  = bank_full_q;
  assign frame_done = frame_done_q;
  assign ovf_err    = ovf_err_q;

  // State registers; reset drops every held or partial frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      wr_bank_q    <= 1'b0;
      wr_blk_q     <= '0;
      bank_full_q  <= '0;
      ovf_err_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_cnt_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      wr_blk_q     <= wr_blk_d;
      bank_full_q  <= bank_full_d;
      ovf_err_q    <= ovf_err_d;
      rd_bank_q    <= rd_bank_d;
      rd_cnt_q     <= rd_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // A write-side set and read-side clear must never target the same bank.
  assert property (@(posedge clk) disable iff (!rstn)
                   !(wr_set && rd_clr && (wr_bank_q == rd_bank_q)));

endmodule

// File: tb/tb_fft_out_pingpong_ctrl.sv
// Scoreboard bench for fft_out_pingpong_ctrl: stimulus pushes expected read addresses,
// a negedge monitor pops and compares on every accepted handshake.
module tb_fft_out_pingpong_ctrl;

  logic       clk;
  logic       rstn;
  logic       cbfp2_pop;
  logic       wr_bank;
  logic [3:0] wr_blk;
  logic [1:0] bank_full;
  logic [9:0] rd_addr;
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;
  logic       ovf_err;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int log_a[0:1023];
  int acc_n = 0;
  bit stall = 1'b0;
  int stall_addr = 0;
  int cyc;

  fft_out_pingpong_ctrl #(
    .BLK_PER_FRAME (16),
    .SAMP_PER_FRAME(512)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cbfp2_pop (cbfp2_pop),
    .wr_bank   (wr_bank),
    .wr_blk    (wr_blk),
    .bank_full (bank_full),
    .rd_addr   (rd_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_done(frame_done),
    .ovf_err   (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int bitrev9(input int v);
    int r = 0;
    for (int i = 0; i < 9; i++) if (v[i]) r |= (1 << (8 - i));
    return r;
  endfunction

  task automatic push_frame(input int bank, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(bank * 512 + bitrev9(i));
  endtask

  // Pops are sampled on the next n rising edges; returns 1 time unit after the last.
  task automatic pop_n(input int n);
    cbfp2_pop = 1'b1;
    repeat (n) @(posedge clk);
    #1 cbfp2_pop = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    exp_q.delete();
    acc_n = 0;
  endtask

  task automatic wait_done(input int max, input bit toggle, output int n);
    bit ok = 1'b0;
    n = 0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
      if (toggle) out_ready = ~out_ready;
    end
    chk("frame_done_seen", ok, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_bank"}, wr_bank, 0);
    chk({tag, "_wr_blk"}, wr_blk, 0);
    chk({tag, "_bank_full"}, bank_full, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_ovf_err"}, ovf_err, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
  endtask

  // Monitor: scoreboard compare on each handshake, stability check after each stall.
  always @(negedge clk) begin
    if (!rstn) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_addr", rd_addr, stall_addr);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got addr %0d with no expected entry", rd_addr);
        end else begin
          int e;
          e = exp_q.pop_front();
          checks--;
          chk("rd_addr", rd_addr, e);
        end
        if (acc_n < 1024) log_a[acc_n] = rd_addr;
        acc_n++;
      end
      stall = out_valid && !out_ready;
      stall_addr = rd_addr;
    end
  end

  initial begin
    rstn = 1'b0;
    cbfp2_pop = 1'b0;
    out_ready = 1'b0;
    #2;
    chk_reset_vals("por");
    @(posedge clk);
    #1 rstn = 1'b1;

    // Single frame, ready held high.
    out_ready = 1'b1;
    acc_n = 0;
    push_frame(0, 512);
    pop_n(16);
    chk("a_bank_full", bank_full, 1);
    chk("a_wr_bank", wr_bank, 1);
    chk("a_wr_blk", wr_blk, 0);
    chk("a_valid_low", out_valid, 0);
    @(posedge clk);
    #1;
    chk("a_valid_high", out_valid, 1);
    chk("a_first_addr", rd_addr, 0);
    wait_done(700, 1'b0, cyc);
    chk("a_cycles", cyc, 512);
    chk("a_bank_full_clr", bank_full, 0);
    chk("a_sb_empty", exp_q.size(), 0);
    chk("a_acc_n", acc_n, 512);
    chk("a_log0", log_a[0], 0);
    chk("a_log1", log_a[1], 256);
    chk("a_log2", log_a[2], 128);
    chk("a_log3", log_a[3], 384);
    chk("a_log511", log_a[511], 511);
    @(posedge clk);
    #1;
    chk("a_fd_pulse", frame_done, 0);

    // Fill both banks with ready low, then overflow, then drain both.
    out_ready = 1'b0;
    do_reset();
    pop_n(32);
    chk("b_bank_full", bank_full, 3);
    chk("b_wr_bank", wr_bank, 0);
    chk("b_wr_blk", wr_blk, 0);
    chk("b_ovf_pre", ovf_err, 0);
    chk("b_valid", out_valid, 1);
    chk("b_addr_hold", rd_addr, 0);
    pop_n(1);
    chk("b_ovf", ovf_err, 1);
    chk("b_wr_blk_ovf", wr_blk, 0);
    chk("b_wr_bank_ovf", wr_bank, 0);
    chk("b_bank_full_ovf", bank_full, 3);
    push_frame(0, 512);
    push_frame(1, 512);
    out_ready = 1'b1;
    wait_done(700, 1'b0, cyc);
    chk("b_bank_full_mid", bank_full, 2);
    wait_done(700, 1'b0, cyc);
    chk("b_bank_full_end", bank_full, 0);
    chk("b_ovf_sticky", ovf_err, 1);
    chk("b_sb_empty", exp_q.size(), 0);
    chk("b_log512", log_a[512], 512);
    chk("b_log513", log_a[513], 768);

    // Ready toggling every cycle: 512 acceptances over 1024 cycles.
    out_ready = 1'b0;
    do_reset();
    push_frame(0, 512);
    pop_n(16);
    wait_done(1200, 1'b1, cyc);
    chk("c_cycles", cyc, 1024);
    chk("c_acc_n", acc_n, 512);
    chk("c_sb_empty", exp_q.size(), 0);

    // Bank 1 completes on the same edge bank 0 finishes draining.
    out_ready = 1'b1;
    do_reset();
    push_frame(0, 512);
    push_frame(1, 512);
    pop_n(16);
    repeat (497) @(posedge clk);
    #1;
    pop_n(16);
    chk("d_bank_full_swap", bank_full, 2);
    chk("d_frame_done", frame_done, 1);
    chk("d_idle_gap", out_valid, 0);
    chk("d_wr_bank", wr_bank, 0);
    @(posedge clk);
    #1;
    chk("d_reenter", out_valid, 1);
    chk("d_addr_b1", rd_addr, 512);
    wait_done(700, 1'b0, cyc);
    chk("d_cycles", cyc, 512);
    chk("d_bank_full_end", bank_full, 0);
    chk("d_sb_empty", exp_q.size(), 0);

    // Asynchronous reset mid-frame with both banks full.
    out_ready = 1'b0;
    do_reset();
    pop_n(32);
    chk("e_bank_full", bank_full, 3);
    push_frame(0, 200);
    out_ready = 1'b1;
    repeat (200) @(posedge clk);
    #1 out_ready = 1'b0;
    chk("e_addr_200", rd_addr, 38);
    #3 rstn = 1'b0;
    #1;
    chk_reset_vals("e_async");
    chk("e_sb_empty", exp_q.size(), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    acc_n = 0;
    out_ready = 1'b1;
    push_frame(0, 512);
    pop_n(1);
    chk("e_first_blk", wr_blk, 1);
    chk("e_first_bank", wr_bank, 0);
    pop_n(15);
    wait_done(700, 1'b0, cyc);
    chk("e_log0", log_a[0], 0);
    chk("e_acc_n", acc_n, 512);
    chk("e_sb_empty_end", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
